// File: rtl/cpu_irq_timer_pkg.sv
// cpu_irq_timer_pkg: register selects, control bit positions and sizing helper for cpu_irq_timer
package cpu_irq_timer_pkg;
  typedef enum logic [1:0] {
    REG_LATCH_LO = 2'd0,
    REG_LATCH_HI = 2'd1,
    REG_CTRL     = 2'd2,
    REG_ACK      = 2'd3
  } reg_sel_e;
  localparam int CTRL_EAA  = 0;
  localparam int CTRL_EN   = 1;
  localparam int CTRL_MODE = 2;
  function automatic int ch_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cpu_irq_timer_if.sv
// cpu_irq_timer_if: mapper-decode write bus and irq outputs of cpu_irq_timer
// master: drives reg_we/reg_ch/reg_sel/reg_data, reads irq_pending/irq
// slave:  reads reg_we/reg_ch/reg_sel/reg_data, drives irq_pending/irq
interface cpu_irq_timer_if #(parameter int CHANNELS = 2);
  import cpu_irq_timer_pkg::*;
  localparam int CW = ch_w(CHANNELS);
  logic                reg_we;
  logic [CW-1:0]       reg_ch;
  logic [1:0]          reg_sel;
  logic [7:0]          reg_data;
  logic [CHANNELS-1:0] irq_pending;
  logic                irq;
  modport master(output reg_we, reg_ch, reg_sel, reg_data, input irq_pending, irq);
  modport slave(input reg_we, reg_ch, reg_sel, reg_data, output irq_pending, irq);
endinterface

// File: rtl/cpu_irq_timer_channel.sv
// irq_timer_channel: one WIDTH-bit irq counter with latch, flags and optional scanline prescaler
// m2/reset: clock and async active-high reset; i_we: write strobe already decoded for this channel
// i_sel/i_data: register select and data; o_pending: overflow flag
// CPU_IRQ_TIMER_SCANLINE_EN defined adds the dot prescaler; undefined runs every channel in cycle mode
module irq_timer_channel
  import cpu_irq_timer_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int PRESCALE_PERIOD = 341
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       i_we,
  input  logic [1:0] i_sel,
  input  logic [7:0] i_data,
  output logic       o_pending
);
  logic [WIDTH-1:0] r_latch, r_counter;
  logic r_enable, r_eaa, r_mode, r_pending;
  logic w_tick;
`ifdef CPU_IRQ_TIMER_SCANLINE_EN
  localparam int PW = $clog2(PRESCALE_PERIOD + 1);
  logic [PW-1:0] r_pre;
  logic w_wrap;
  assign w_wrap = r_pre <= PW'(3);
  assign w_tick = r_enable & (r_mode | w_wrap);
  always_ff @(posedge m2 or posedge reset)
    if (reset) r_pre <= PW'(PRESCALE_PERIOD);
    else if (i_we) r_pre <= (i_sel == REG_CTRL && i_data[CTRL_EN]) ? PW'(PRESCALE_PERIOD) : r_pre;
    else if (r_enable && !r_mode) r_pre <= w_wrap ? r_pre + PW'(PRESCALE_PERIOD - 3) : r_pre - PW'(3);
`else
  // mode is stored for software but never selects the prescaler here
  assign w_tick = r_enable & (r_mode | 1'b1);
`endif
  always_ff @(posedge m2 or posedge reset)
    if (reset) begin
      r_latch   <= '0;
      r_counter <= '0;
      r_enable  <= 1'b0;
      r_eaa     <= 1'b0;
      r_mode    <= 1'b0;
      r_pending <= 1'b0;
    end else if (i_we) begin
      if (i_sel == REG_LATCH_LO) r_latch <= (r_latch & ~WIDTH'(8'hFF)) | WIDTH'(i_data);
      // truncating cast drops bits above WIDTH and leaves an 8-bit latch untouched
      if (i_sel == REG_LATCH_HI) r_latch <= WIDTH'({i_data, r_latch[7:0]});
      if (i_sel == REG_CTRL) begin
        r_eaa     <= i_data[CTRL_EAA];
        r_enable  <= i_data[CTRL_EN];
        r_mode    <= i_data[CTRL_MODE];
        r_pending <= 1'b0;
        if (i_data[CTRL_EN]) r_counter <= r_latch;
      end
      if (i_sel == REG_ACK) begin
        r_pending <= 1'b0;
        r_enable  <= r_eaa;
      end
    end else if (w_tick) begin
      r_counter <= &r_counter ? r_latch : r_counter + WIDTH'(1);
      if (&r_counter) r_pending <= 1'b1;
    end
  assign o_pending = r_pending;
endmodule

// File: rtl/cpu_irq_timer.sv
// cpu_irq_timer: CHANNELS-way CPU-cycle irq timer with write decode and registered active-low irq
// m2/reset: clock and async active-high reset; bus: slave side of cpu_irq_timer_if
// CPU_IRQ_TIMER_SCANLINE_EN enables per-channel scanline prescaling
module cpu_irq_timer
  import cpu_irq_timer_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int WIDTH           = 8,
  parameter int PRESCALE_PERIOD = 341
) (
  input logic            m2,
  input logic            reset,
  cpu_irq_timer_if.slave bus
);
  localparam int CW = ch_w(CHANNELS);
  logic [CHANNELS-1:0] w_pending;
  logic r_irq;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    irq_timer_channel #(.WIDTH(WIDTH), .PRESCALE_PERIOD(PRESCALE_PERIOD)) u_ch (
      .m2       (m2),
      .reset    (reset),
      .i_we     (bus.reg_we && bus.reg_ch == CW'(c)),
      .i_sel    (bus.reg_sel),
      .i_data   (bus.reg_data),
      .o_pending(w_pending[c])
    );
  end
  always_ff @(posedge m2 or posedge reset)
    if (reset) r_irq <= 1'b1;
    else r_irq <= ~|w_pending;
  assign bus.irq_pending = w_pending;
  assign bus.irq         = r_irq;
endmodule

// File: tb/tb_cpu_irq_timer.sv
// tb_cpu_irq_timer: scoreboarded random/directed bench for cpu_irq_timer against a behavioural model
module tb_cpu_irq_timer;
  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int P   = 341;
  localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int MAX = (1 << W) - 1;
`ifdef CPU_IRQ_TIMER_SCANLINE_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif
  logic m2 = 1'b0;
  logic reset = 1'b1;
  cpu_irq_timer_if #(.CHANNELS(CH)) bus ();
  cpu_irq_timer #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_PERIOD(P)) dut (
    .m2   (m2),
    .reset(reset),
    .bus  (bus)
  );
  always #5 m2 = ~m2;
  int checks = 0;
  int errors = 0;
  logic [CH:0] q[$];
  int lat[CH], cnt[CH], pre[CH];
  bit en[CH], eaa[CH], md[CH], pend[CH];
  task automatic check(string name, logic [CH:0] act, logic [CH:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s {pending,irq} got %b want %b at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge m2) if (q.size() > 0) check("cycle", {bus.irq_pending, bus.irq}, q.pop_front());
  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      lat[c] = 0; cnt[c] = 0; pre[c] = P;
      en[c] = 0; eaa[c] = 0; md[c] = 0; pend[c] = 0;
    end
  endfunction
  function automatic void model(bit we, int ch, int sel, int d);
    bit any;
    logic [CH-1:0] p;
    any = 0;
    for (int c = 0; c < CH; c++) any |= pend[c];
    for (int c = 0; c < CH; c++) begin
      if (we && ch == c) begin
        case (sel)
          0: lat[c] = (lat[c] & MAX & ~'hFF) | d;
          1: if (W > 8) lat[c] = (lat[c] & 'hFF) | ((d << 8) & MAX);
          2: begin
            eaa[c] = d[0]; en[c] = d[1]; md[c] = d[2]; pend[c] = 0;
            if (en[c]) begin cnt[c] = lat[c]; pre[c] = P; end
          end
          default: begin pend[c] = 0; en[c] = eaa[c]; end
        endcase
      end else if (en[c]) begin
        bit tick;
        tick = 1;
        if (SCAN && !md[c]) begin
          if (pre[c] <= 3) pre[c] += P - 3;
          else begin pre[c] -= 3; tick = 0; end
        end
        if (tick) begin
          if (cnt[c] == MAX) begin cnt[c] = lat[c]; pend[c] = 1; end
          else cnt[c]++;
        end
      end
    end
    for (int c = 0; c < CH; c++) p[c] = pend[c];
    q.push_back({p, ~any});
  endfunction
  task automatic step(bit we, int ch, int sel, int d);
    bus.reg_we = we; bus.reg_ch = CW'(ch); bus.reg_sel = 2'(sel); bus.reg_data = 8'(d);
    @(posedge m2);
    model(we, ch, sel, d);
    #1 bus.reg_we = 1'b0;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  task automatic rand_run(int n);
    for (int i = 0; i < n; i++)
      if ($urandom_range(0, 7) == 0)
        step(1, $urandom_range(0, (1 << CW) - 1), $urandom_range(0, 3),
             $urandom_range(0, 1) ? $urandom_range(0, 255) : $urandom_range(240, 255));
      else idle(1);
  endtask
  task automatic mid_reset();
    @(negedge m2);
    #1 reset = 1'b1;
    #1 check("async_reset", {bus.irq_pending, bus.irq}, {{CH{1'b0}}, 1'b1});
    @(posedge m2);
    #1 check("held_reset", {bus.irq_pending, bus.irq}, {{CH{1'b0}}, 1'b1});
    @(negedge m2);
    #1 reset = 1'b0;
    model_reset();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    bus.reg_we = 1'b0; bus.reg_ch = '0; bus.reg_sel = '0; bus.reg_data = '0;
    model_reset();
    #23 check("reset_state", {bus.irq_pending, bus.irq}, {{CH{1'b0}}, 1'b1});
    @(negedge m2);
    #1 reset = 1'b0;
    idle(1000);
    step(1, 0, 0, 'hFD); step(1, 0, 2, 'h06); idle(8);
    step(1, 0, 2, 'h07); idle(4); step(1, 0, 3, 0); idle(6);
    step(1, 0, 2, 'h06); idle(5); step(1, 0, 3, 0); idle(500);
    step(1, 0, 0, 'hFE); step(1, 0, 2, 'h03); idle(240);
    step(1, 0, 3, 0);
    step(1, 0, 0, 'hFE); step(1, 0, 2, 'h03);
    step(1, 1, 0, 'hFF); step(1, 1, 2, 'h07);
    for (int i = 0; i < 300; i++) step(1, 1, 3, 0);
    step(1, 0, 0, 'hF8); step(1, 0, 1, 'h5A); step(1, 0, 2, 'h06); idle(40);
    rand_run(3000);
    mid_reset();
    rand_run(600);
    idle(3);
    @(negedge m2);
    #1 checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
